pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_buf.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Inter-stage pipeline register with a valid/ready handshake and a
//   two-entry skid buffer (main entry + skid entry). Entries leave in
//   strict FIFO order. in_ready, out_valid and occupancy are decoded
//   only from the state register, so backpressure never forms a
//   combinational path from out_ready to in_ready.
//
// Parameters
//   DATA_W          width of one payload lane
//   LANES           number of lanes; payload width PW = LANES*DATA_W
//   CLEAR_ON_FLUSH  1: flush also zeroes both payload entries
//                   0: flush clears only the occupancy state
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   flush      in   synchronous flush, kills all held entries
//   in_valid   in   upstream entry valid
//   in_data    in   upstream payload [PW-1:0]
//   in_ready   out  stage can accept an entry this cycle
//   out_valid  out  downstream entry valid
//   out_data   out  downstream payload (main entry) [PW-1:0]
//   out_ready  in   downstream accepts; 0 = stall
//   occupancy  out  entries held (0, 1 or 2)
//
// Optional feature, macro PIPE_STAGE_PERF_CNT_EN:
//   stall_cnt  out  cycles with out_valid & !out_ready (wraps mod 2^32)
//   bubble_cnt out  cycles with !out_valid & !flush   (wraps mod 2^32)
//   Both are cleared only by reset; flush does not touch them.

module pipe_stage_buf #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LANES          = 4,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      out_ready,
`ifdef PIPE_STAGE_PERF_CNT_EN
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt,
`endif
  output logic [1:0]                occupancy
);

  localparam int unsigned PW = LANES * DATA_W;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PW-1:0]   main_r;
  logic [PW-1:0]   main_nxt_s;
  logic [PW-1:0]   skid_r;
  logic [PW-1:0]   skid_nxt_s;
  logic            in_fire_s;
  logic            out_fire_s;

  // Handshake outputs straight from the state flops.
  assign in_ready   = (state_r != FULL);
  assign out_valid  = (state_r != EMPTY);
  assign occupancy  = state_r;
  assign out_data   = main_r;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Next-state and payload-steering decode; flush overrides any fire.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nxt_s = '0;
        skid_nxt_s = '0;
      end else begin
        main_nxt_s = main_r;
        skid_nxt_s = skid_r;
      end
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else if (in_fire_s) begin
            // Main is stalled; the new entry parks in the skid slot.
            state_nxt_s = FULL;
            skid_nxt_s  = in_data;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_nxt_s = EMPTY;
          main_nxt_s  = '0;
          skid_nxt_s  = '0;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] bubble_cnt_r;

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;

  // Performance counters; wrap naturally, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!out_valid && !flush) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned PW     = DATA_W * LANES;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [PW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  int checks_r;
  int errors_r;

  pipe_stage_buf #(
    .DATA_W         (DATA_W),
    .LANES          (LANES),
    .CLEAR_ON_FLUSH (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef PIPE_STAGE_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .occupancy  (occupancy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct value per lane so lane swaps are visible.
  function automatic logic [PW-1:0] pay(input logic [31:0] k);
    pay = {k + 32'd3, k + 32'd2, k + 32'd1, k};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks_r = checks_r + 1;
    if (got !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic [PW-1:0] dat);
    check({tag, ".occ"},   {126'd0, occupancy}, {126'd0, occ});
    check({tag, ".vld"},   {127'd0, out_valid}, {127'd0, (occ != 2'd0)});
    check({tag, ".rdy"},   {127'd0, in_ready},  {127'd0, (occ != 2'd2)});
    check({tag, ".data"},  out_data, dat);
  endtask

  task automatic fill_two(input logic [PW-1:0] a, input logic [PW-1:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_data   = b;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    checks_r  = 0;
    errors_r  = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    chk_state("rst", 2'd0, '0);
    step();
    step();
    reset = 1'b1;

    // Streaming at full throughput: 1..8 emerge on consecutive cycles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = pay(32'(i));
      step();
      chk_state($sformatf("stream%0d", i), 2'd1, pay(32'(i)));
    end
    in_valid = 1'b0;
    step();
    chk_state("stream_drain", 2'd0, pay(32'd8));

    // Stall fills both entries; release pops A then B in order.
    fill_two(pay(32'hA0), pay(32'hB0));
    chk_state("stall_full", 2'd2, pay(32'hA0));
    step();
    chk_state("stall_hold", 2'd2, pay(32'hA0));
    out_ready = 1'b1;
    step();
    chk_state("pop_a", 2'd1, pay(32'hB0));
    step();
    chk_state("pop_b", 2'd0, pay(32'hB0));

    // FULL with simultaneous pop and offer: C is refused, then taken.
    fill_two(pay(32'h100), pay(32'h200));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pay(32'h300);
    step();
    chk_state("full_pop", 2'd1, pay(32'h200));
    step();
    chk_state("c_taken", 2'd1, pay(32'h300));
    in_valid = 1'b0;
    step();
    chk_state("c_drain", 2'd0, pay(32'h300));

    // Asynchronous reset while FULL clears everything at once.
    fill_two(pay(32'h400), pay(32'h500));
    chk_state("pre_rst", 2'd2, pay(32'h400));
    #2;
    reset = 1'b0;
    #1;
    chk_state("mid_rst", 2'd0, '0);
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pay(32'h600);
    step();
    chk_state("post_rst", 2'd1, pay(32'h600));
    in_valid = 1'b0;
    step();

    // Flush while FULL drops the offered 0xDEAD and zeroes payload.
    fill_two(pay(32'h700), pay(32'h800));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {{(PW-16){1'b0}}, 16'hDEAD};
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_state("flush", 2'd0, '0);
    out_ready = 1'b1;
    step();
    chk_state("flush_after", 2'd0, '0);

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Counters from a fresh reset: load cycle (1 bubble), 5 stalls,
    // one pop, then 3 idle cycles.
    reset = 1'b0;
    #1;
    check("cnt_rst_stall", {96'd0, stall_cnt}, '0);
    step();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pay(32'h900);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("cnt_stall5", {96'd0, stall_cnt}, {96'd0, 32'd5});
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    check("cnt_stall_keep", {96'd0, stall_cnt}, {96'd0, 32'd5});
    check("cnt_bubble", {96'd0, bubble_cnt}, {96'd0, 32'd4});
    // Wrap: preload all-ones, one more stall cycle gives 0.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pay(32'hA00);
    step();
    in_valid = 1'b0;
    force dut.stall_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_r;
    step();
    check("cnt_wrap", {96'd0, stall_cnt}, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
